// File: rtl/rr_dist4_pkg.sv
// Shared definitions for the four-way round-robin packet distributor.
package rr_dist4_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Lane after l in rotation order; 2-bit wrap makes 3 -> 0.
  function automatic lane_t lane_next(input lane_t l);
    return lane_t'(l + 1'b1);
  endfunction

endpackage

// File: rtl/rr_dist4_if.sv
// Beat-stream bus for rr_dist4: one input stream and four output lanes.
interface rr_dist4_if #(
  parameter int unsigned DW = 64
);

  logic                                    in_valid;
  logic                                    in_sop;
  logic                                    in_eop;
  logic [DW-1:0]                           in_data;
  logic                                    in_ready;

  logic [rr_dist4_pkg::NUM_LANES-1:0]      out_valid;
  logic [rr_dist4_pkg::NUM_LANES-1:0]      out_sop;
  logic [rr_dist4_pkg::NUM_LANES-1:0]      out_eop;
  logic [rr_dist4_pkg::NUM_LANES*DW-1:0]   out_data;
  logic [rr_dist4_pkg::NUM_LANES-1:0]      out_ready;

  // Source of beats and sink of the lanes.
  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_data
  );

  // The distributor itself.
  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_data
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotated-priority first-free lane finder: scans ptr, ptr+1, ptr+2, ptr+3.
module rr_pick4
  import rr_dist4_pkg::*;
(
  input  logic [NUM_LANES-1:0] free,
  input  lane_t                ptr,
  output lane_t                lane,
  output logic                 any_free
);

  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0]   rot;
  lane_t                  idx;

  // Rotate so bit 0 is the ptr lane, take the lowest set bit, rotate back.
  always_comb begin
    dbl      = {free, free};
    rot      = NUM_LANES'(dbl >> ptr);
    idx      = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rot[i]) idx = LANE_W'(i);
    end
    lane     = lane_t'(ptr + idx);
    any_free = |free;
  end

endmodule

// File: rtl/rr_dist4.sv
// Four-way round-robin packet distributor: whole packets rotate across four
// registered output lanes in rotated-priority order.
module rr_dist4
  import rr_dist4_pkg::*;
#(
  parameter int unsigned DW = 64
)(
  input  logic      clk,
  input  logic      rst,
  rr_dist4_if.slave bus,
  output lane_t     cur_lane,
  output logic      err
);

  state_t               state;
  lane_t                ptr;
  lane_t                lane_q;
  lane_t                pick_lane;
  lane_t                tgt;
  logic                 any_free;
  logic                 in_ready_c;
  logic                 accept;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] free;

  assign free = ~lane_valid | bus.out_ready;

  rr_pick4 u_pick (
    .free     (free),
    .ptr      (ptr),
    .lane     (pick_lane),
    .any_free (any_free)
  );

  // Target lane and ready: locked lane mid-packet, otherwise next free lane.
  always_comb begin
    tgt        = pick_lane;
    in_ready_c = any_free;
    if (state == ST_LOCKED) begin
      tgt        = lane_q;
      in_ready_c = free[lane_q];
    end
    if (rst) in_ready_c = 1'b0;
  end

  assign accept       = bus.in_valid & in_ready_c;
  assign bus.in_ready = in_ready_c;
  assign cur_lane     = rst ? '0 : tgt;

  // Packet framing FSM, rotation pointer and sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      lane_q <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        if (!bus.in_sop) err <= 1'b1;
        if (bus.in_eop) begin
          ptr <= lane_next(pick_lane);
        end else begin
          state  <= ST_LOCKED;
          lane_q <= pick_lane;
        end
      end else begin
        if (bus.in_sop) err <= 1'b1;
        if (bus.in_eop) begin
          state <= ST_IDLE;
          ptr   <= lane_next(lane_q);
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic          v_q;
    logic          sop_q;
    logic          eop_q;
    logic [DW-1:0] data_q;
    logic          load;

    assign load = accept && (tgt == LANE_W'(n));

    // One-entry holding register; a load wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q    <= 1'b0;
        sop_q  <= 1'b0;
        eop_q  <= 1'b0;
        data_q <= '0;
      end else if (load) begin
        v_q    <= 1'b1;
        sop_q  <= bus.in_sop;
        eop_q  <= bus.in_eop;
        data_q <= bus.in_data;
      end else if (bus.out_ready[n]) begin
        v_q    <= 1'b0;
      end
    end

    assign lane_valid[n]            = v_q;
    assign bus.out_valid[n]         = v_q;
    assign bus.out_sop[n]           = sop_q;
    assign bus.out_eop[n]           = eop_q;
    assign bus.out_data[n*DW +: DW] = data_q;
  end

endmodule

// File: doc/rr_dist4.md
# rr_dist4

Four-way round-robin packet distributor. It is the fan-out counterpart of the four-input round-robin arbiter: one input beat stream is spread across four output lanes, one whole packet per lane at a time. The lane choice rotates in the same rotated-priority order the arbiter uses for grants. It sits ahead of four parallel processing pipes, and each output lane has a one-entry register stage.

## Interface
Parameters:
- DW, 64, data width of one beat

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_sop  in  1  input beat is first of packet
- in_eop  in  1  input beat is last of packet
- in_data  in  DW  input beat data
- in_ready  out  1  input beat accepted when in_valid & in_ready
- out_valid  out  4  per-lane beat valid
- out_sop  out  4  per-lane start of packet
- out_eop  out  4  per-lane end of packet
- out_data  out  4*DW  lane n on bits [n*DW +: DW]
- out_ready  in  4  per-lane downstream ready
- cur_lane  out  2  lane of packet in progress, or next candidate lane when idle
- err  out  1  sticky framing error

## Operation
- Per-lane holding register: valid, sop, eop, data.
- free[n] = !out_valid[n] | out_ready[n].
- A lane register loads when its beat is accepted.
- A lane register clears valid when out_ready[n] is high and no new beat is loaded.
- 2-bit pointer ptr: the highest-priority lane for the next new packet.
- FSM IDLE:
  - Target lane = first n with free[n], scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - in_ready = |free.
  - cur_lane = target lane.
- Accept in IDLE:
  - Beat is written to the target lane.
  - If !in_eop: go to LOCKED, lane := target.
  - If in_eop (single-beat packet): stay IDLE, ptr := target+1.
- FSM LOCKED:
  - in_ready = free[lane].
  - cur_lane = lane.
  - Every accepted beat goes to that lane.
  - Accept with in_eop: go to IDLE, ptr := lane+1.
  - ptr is unchanged while LOCKED.
- Pointer arithmetic is 2-bit and wraps: 3+1 = 0.
- Framing errors (err set, held until reset):
  - Beat accepted in IDLE with !in_sop. The beat is still routed as a packet start.
  - Beat accepted in LOCKED with in_sop. The beat is still treated as a continuation of the current packet.
- Other lanes keep draining independently while one lane is locked.
- Beat data and flags pass through unmodified.

## Timing
- Reset, applied synchronously at clk:
  - out_valid = 0, out_sop = 0, out_eop = 0, out_data = 0.
  - ptr = 0, state = IDLE, err = 0, cur_lane = 0.
  - in_ready = 0 while rst is high.
- Latency: a beat accepted in cycle t is presented on out_*[lane] in cycle t+1.
- Throughput: one beat per cycle while the target lane's downstream keeps out_ready high.
- in_ready is combinational from out_ready, the lane registers and the FSM. There is no combinational path from in_valid to in_ready.
- Simultaneous out_ready[n] and accept into lane n: the lane reloads with the new beat and out_valid[n] stays 1.
- All four lanes full in IDLE: in_ready = 0 and ptr holds.
- Reset mid-packet: the partial packet is abandoned and lane registers are cleared. The next beat must carry sop, otherwise err sets.

## Structure
- Shared package: lane count constant (4), lane index width (2), FSM state encoding (IDLE, LOCKED).
- Sub-module rr_pick4: combinational rotated-priority first-free finder. Inputs are free[3:0] and ptr[1:0]. Outputs are lane[1:0] and any_free. It uses the same rotate-then-priority method as the arbiter.
- Top level holds the FSM, the pointer, the err flag and four lane registers (generate loop).

## Test plan
- All out_ready = 1; four single-beat packets A, B, C, D on consecutive cycles -> A on lane 0, B on 1, C on 2, D on 3. Each appears one cycle after acceptance, and ptr returns to 0.
- 3-beat packet with out_ready = 4'b1111 -> all three beats on lane 0 in consecutive cycles. A following packet goes to lane 1.
- ptr = 1, lanes 1 and 2 full with out_ready low, new sop beat -> routed to lane 3. The next packet after that one goes to lane 0 (wrap).
- LOCKED on lane 2 with out_ready[2] = 0 and the lane full -> in_ready = 0 even though lanes 0, 1 and 3 are free. Raise out_ready[2] -> the beat is accepted that cycle and out_valid[2] stays 1.
- Beat without sop in IDLE -> routed to the target lane and err = 1 from the next cycle. Also: sop inside a packet -> err = 1, beat stays on the locked lane.
- Assert rst during beat 2 of a 4-beat packet -> next cycle all out_valid = 0, ptr = 0, err = 0, state IDLE. A fresh sop packet then goes to lane 0.
